// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Constants shared by the write-register select mux, the register file
//   and the forwarding unit, so all three agree on register address and
//   data widths and on which register is hardwired to zero.
package register_file_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// regfile_read_port
//   One combinational read port of the register file. It picks between a
//   forced zero, the write-back bypass and the stored word.
//
// Ports:
//   rst    in   1           reset; forces the output to zero while high
//   raddr  in   ADDR_WIDTH  register being read
//   word   in   DATA_WIDTH  array contents at raddr
//   we     in   1           write enable of the write port
//   waddr  in   ADDR_WIDTH  destination of the write port
//   wdata  in   DATA_WIDTH  data on the write port
//   rdata  out  DATA_WIDTH  read result
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    // The zero-register check sits above the bypass so that an attempted
    // write to register 0 can never leak its data into a same-cycle read.
    always_comb begin
        rdata = word;
        if (rst) begin
            rdata = '0;
        end else if (raddr == '0) begin
            rdata = '0;
        end else if (we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// register_file
//   Two-read, one-write general-purpose register file. Register 0 reads
//   as zero, and a write is forwarded to both read ports in the same cycle
//   so write-back/decode hazards need no stall.
//
// Ports:
//   clk     in   1           clock, all updates on the rising edge
//   rst     in   1           synchronous active-high reset, clears every register
//   we      in   1           write enable
//   waddr   in   ADDR_WIDTH  write destination register
//   wdata   in   DATA_WIDTH  write-back data
//   raddr1  in   ADDR_WIDTH  read port 1 address (rs)
//   raddr2  in   ADDR_WIDTH  read port 2 address (rt)
//   rdata1  out  DATA_WIDTH  read port 1 data
//   rdata2  out  DATA_WIDTH  read port 2 data
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wins over a simultaneous write. Register 0 is never written,
    // so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port1 (
        .rst   (rst),
        .raddr (raddr1),
        .word  (mem[raddr1]),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port2 (
        .rst   (rst),
        .raddr (raddr2),
        .word  (mem[raddr2]),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata2)
    );

endmodule : register_file
